// File: rtl/instructions_pkg.sv
// Shared RV32 instruction types and decoded-bundle layout for the decode stage.
package instructions_pkg;

    typedef logic [31:0] instruction_t;

    // Opcodes the decoder supports; anything else is flagged illegal.
    typedef enum logic [6:0] {
        r_type   = 7'b0110011,
        i_type   = 7'b0010011,
        s_type   = 7'b0100011,
        b_type   = 7'b1100011,
        u_type   = 7'b0010111,
        j_type   = 7'b1101111,
        custom_0 = 7'b0001011
    } inst_type_e;

    typedef enum logic [2:0] {
        beq  = 3'b000,
        bne  = 3'b001,
        blt  = 3'b100,
        bge  = 3'b101,
        bltu = 3'b110,
        bgeu = 3'b111
    } func3_b_type_e;

    // custom_0 only defines the idle operation.
    typedef enum logic [2:0] {
        idle = 3'b000
    } func3_custom_e;

    localparam logic [6:0] FUNCT7_BASE = 7'h00;
    localparam logic [6:0] FUNCT7_ALT  = 7'h20;

    // inst_type carries raw opcode bits so illegal opcodes stay visible.
    typedef struct packed {
        logic [6:0]  inst_type;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic        illegal;
    } decoded_inst_t;

endpackage

// File: rtl/riscv_imm_gen.sv
// Combinational immediate extraction for the supported RV32 formats.
module riscv_imm_gen
    import instructions_pkg::*;
(
    input  instruction_t inst,
    output logic [31:0]  imm
);

    // Select and sign-extend the immediate by opcode; R, custom_0 and unknown give 0.
    always_comb begin
        imm = '0;
        case (inst[6:0])
            i_type:  imm = {{20{inst[31]}}, inst[31:20]};
            s_type:  imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            b_type:  imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            u_type:  imm = {inst[31:12], 12'b0};
            j_type:  imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/riscv_inst_decoder.sv
// RV32 decode stage: combinational decode into a registered output slot backed
// by a one-entry skid register, plus delivered/illegal bundle counters.
module riscv_inst_decoder
    import instructions_pkg::*;
#(
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned ILL_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_inst,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [6:0]           out_type,
    output logic [4:0]           out_rd,
    output logic [4:0]           out_rs1,
    output logic [4:0]           out_rs2,
    output logic [2:0]           out_funct3,
    output logic [6:0]           out_funct7,
    output logic [31:0]          out_imm,
    output logic                 out_illegal,
    output logic [CNT_W-1:0]     decoded_cnt,
    output logic [ILL_CNT_W-1:0] illegal_cnt
);

    decoded_inst_t dec;
    decoded_inst_t or_q, or_d, sk_q, sk_d;
    logic          or_valid_q, or_valid_d, sk_valid_q, sk_valid_d;
    logic [31:0]   imm;
    logic          accept, or_free, out_hs;
    logic [CNT_W-1:0]     dec_cnt_q;
    logic [ILL_CNT_W-1:0] ill_cnt_q;

    riscv_imm_gen u_imm_gen (
        .inst (in_inst),
        .imm  (imm)
    );

    // Decode the incoming word; fields not defined for a format stay zero.
    always_comb begin
        dec           = '0;
        dec.inst_type = in_inst[6:0];
        case (in_inst[6:0])
            r_type: begin
                dec.rd      = in_inst[11:7];
                dec.rs1     = in_inst[19:15];
                dec.rs2     = in_inst[24:20];
                dec.funct3  = in_inst[14:12];
                dec.funct7  = in_inst[31:25];
                dec.illegal = !((in_inst[31:25] == FUNCT7_BASE) ||
                                (in_inst[31:25] == FUNCT7_ALT &&
                                 (in_inst[14:12] == 3'b000 || in_inst[14:12] == 3'b101)));
            end
            i_type: begin
                dec.rd     = in_inst[11:7];
                dec.rs1    = in_inst[19:15];
                dec.funct3 = in_inst[14:12];
                dec.imm    = imm;
                // Shift-immediates expose funct7 and constrain it.
                if (in_inst[14:12] == 3'b001) begin
                    dec.funct7  = in_inst[31:25];
                    dec.illegal = (in_inst[31:25] != FUNCT7_BASE);
                end else if (in_inst[14:12] == 3'b101) begin
                    dec.funct7  = in_inst[31:25];
                    dec.illegal = (in_inst[31:25] != FUNCT7_BASE) &&
                                  (in_inst[31:25] != FUNCT7_ALT);
                end
            end
            s_type: begin
                dec.rs1     = in_inst[19:15];
                dec.rs2     = in_inst[24:20];
                dec.funct3  = in_inst[14:12];
                dec.imm     = imm;
                dec.illegal = (in_inst[14:12] > 3'b010);
            end
            b_type: begin
                dec.rs1     = in_inst[19:15];
                dec.rs2     = in_inst[24:20];
                dec.funct3  = in_inst[14:12];
                dec.imm     = imm;
                dec.illegal = (in_inst[14:12] == 3'b010) || (in_inst[14:12] == 3'b011);
            end
            u_type, j_type: begin
                dec.rd  = in_inst[11:7];
                dec.imm = imm;
            end
            custom_0: begin
                dec.rd      = in_inst[11:7];
                dec.rs1     = in_inst[19:15];
                dec.rs2     = in_inst[24:20];
                dec.funct3  = in_inst[14:12];
                dec.illegal = (in_inst[14:12] != idle);
            end
            default: dec.illegal = 1'b1;
        endcase
        if (dec.illegal) begin
            dec           = '0;
            dec.inst_type = in_inst[6:0];
            dec.illegal   = 1'b1;
        end
    end

    assign accept   = in_valid && in_ready;
    assign out_hs   = or_valid_q && out_ready;
    assign or_free  = !or_valid_q || out_ready;

    // Skid buffer next state: SK refills OR first so ordering stays FIFO.
    always_comb begin
        or_d       = or_q;
        sk_d       = sk_q;
        or_valid_d = or_valid_q;
        sk_valid_d = sk_valid_q;
        if (flush) begin
            or_valid_d = 1'b0;
            sk_valid_d = 1'b0;
        end else if (or_free) begin
            if (sk_valid_q) begin
                or_d       = sk_q;
                or_valid_d = 1'b1;
                sk_valid_d = accept;
                if (accept) sk_d = dec;
            end else begin
                or_valid_d = accept;
                if (accept) or_d = dec;
            end
        end else if (accept) begin
            sk_d       = dec;
            sk_valid_d = 1'b1;
        end
    end

    // Buffer state and counters; a handshake in a flush cycle still counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            or_q       <= '0;
            sk_q       <= '0;
            or_valid_q <= 1'b0;
            sk_valid_q <= 1'b0;
            dec_cnt_q  <= '0;
            ill_cnt_q  <= '0;
        end else begin
            or_q       <= or_d;
            sk_q       <= sk_d;
            or_valid_q <= or_valid_d;
            sk_valid_q <= sk_valid_d;
            if (out_hs) begin
                dec_cnt_q <= dec_cnt_q + CNT_W'(1);
                if (or_q.illegal && ill_cnt_q != '1) begin
                    ill_cnt_q <= ill_cnt_q + ILL_CNT_W'(1);
                end
            end
        end
    end

    assign in_ready    = !sk_valid_q;
    assign out_valid   = or_valid_q;
    assign out_type    = or_q.inst_type;
    assign out_rd      = or_q.rd;
    assign out_rs1     = or_q.rs1;
    assign out_rs2     = or_q.rs2;
    assign out_funct3  = or_q.funct3;
    assign out_funct7  = or_q.funct7;
    assign out_imm     = or_q.imm;
    assign out_illegal = or_q.illegal;
    assign decoded_cnt = dec_cnt_q;
    assign illegal_cnt = ill_cnt_q;

endmodule

// File: tb/tb_riscv_inst_decoder.sv
// Directed table-driven bench for riscv_inst_decoder plus handshake sequences.
module tb_riscv_inst_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_inst = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [6:0]  out_type;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [31:0] out_imm;
    logic        out_illegal;
    logic [31:0] decoded_cnt;
    logic [15:0] illegal_cnt;

    int total = 0;
    int bad   = 0;

    riscv_inst_decoder #(
        .CNT_W     (32),
        .ILL_CNT_W (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_type    (out_type),
        .out_rd      (out_rd),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_funct3  (out_funct3),
        .out_funct7  (out_funct7),
        .out_imm     (out_imm),
        .out_illegal (out_illegal),
        .decoded_cnt (decoded_cnt),
        .illegal_cnt (illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [6:0]  typ;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        ill;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    localparam logic [31:0] W1 = 32'h002080B3;  // add x1,x1,x2
    localparam logic [31:0] W2 = 32'h00208133;  // add x2,x1,x2
    localparam logic [31:0] W3 = 32'h002081B3;  // add x3,x1,x2

    initial begin
        //          inst           type   rd  rs1 rs2 f3   f7     imm            ill
        vecs[0]  = '{32'hFFF00093, 7'h13, 1,  0,  0,  0,   7'h00, 32'hFFFFFFFF, 0};
        vecs[1]  = '{32'h0020A423, 7'h23, 0,  1,  2,  2,   7'h00, 32'h00000008, 0};
        vecs[2]  = '{32'hFFDFF0EF, 7'h6F, 1,  0,  0,  0,   7'h00, 32'hFFFFFFFC, 0};
        vecs[3]  = '{32'h00208863, 7'h63, 0,  1,  2,  0,   7'h00, 32'h00000010, 0};
        vecs[4]  = '{32'h00000003, 7'h03, 0,  0,  0,  0,   7'h00, 32'h00000000, 1};
        vecs[5]  = '{32'h40101093, 7'h13, 0,  0,  0,  0,   7'h00, 32'h00000000, 1};
        vecs[6]  = '{32'h002081B3, 7'h33, 3,  1,  2,  0,   7'h00, 32'h00000000, 0};
        vecs[7]  = '{32'h402081B3, 7'h33, 3,  1,  2,  0,   7'h20, 32'h00000000, 0};
        vecs[8]  = '{32'h402091B3, 7'h33, 0,  0,  0,  0,   7'h00, 32'h00000000, 1};
        vecs[9]  = '{32'h12345297, 7'h17, 5,  0,  0,  0,   7'h00, 32'h12345000, 0};
        vecs[10] = '{32'h40315093, 7'h13, 1,  2,  0,  5,   7'h20, 32'h00000403, 0};
        vecs[11] = '{32'h0020818B, 7'h0B, 3,  1,  2,  0,   7'h00, 32'h00000000, 0};
        vecs[12] = '{32'h0020918B, 7'h0B, 0,  0,  0,  0,   7'h00, 32'h00000000, 1};
        vecs[13] = '{32'h0020B423, 7'h23, 0,  0,  0,  0,   7'h00, 32'h00000000, 1};
        vecs[14] = '{32'h0020A863, 7'h63, 0,  0,  0,  0,   7'h00, 32'h00000000, 1};
        vecs[15] = '{32'hFE209CE3, 7'h63, 0,  1,  2,  1,   7'h00, 32'hFFFFFFF8, 0};

        // Reset state while rst_n is low.
        #12;
        check("rst out_valid", {31'b0, out_valid}, 32'd0);
        check("rst in_ready", {31'b0, in_ready}, 32'd1);
        check("rst out_imm", out_imm, 32'd0);
        check("rst out_type", {25'b0, out_type}, 32'd0);
        check("rst decoded_cnt", decoded_cnt, 32'd0);
        check("rst illegal_cnt", {16'b0, illegal_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: one word per cycle, out_ready high, checked one cycle after accept.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_inst  = vecs[i].inst;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check($sformatf("v%0d valid", i), {31'b0, out_valid}, 32'd1);
            check($sformatf("v%0d type", i), {25'b0, out_type}, {25'b0, vecs[i].typ});
            check($sformatf("v%0d rd", i), {27'b0, out_rd}, {27'b0, vecs[i].rd});
            check($sformatf("v%0d rs1", i), {27'b0, out_rs1}, {27'b0, vecs[i].rs1});
            check($sformatf("v%0d rs2", i), {27'b0, out_rs2}, {27'b0, vecs[i].rs2});
            check($sformatf("v%0d funct3", i), {29'b0, out_funct3}, {29'b0, vecs[i].f3});
            check($sformatf("v%0d funct7", i), {25'b0, out_funct7}, {25'b0, vecs[i].f7});
            check($sformatf("v%0d imm", i), out_imm, vecs[i].imm);
            check($sformatf("v%0d illegal", i), {31'b0, out_illegal}, {31'b0, vecs[i].ill});
            if (i == 0) check("v0 decoded_cnt before drain", decoded_cnt, 32'd0);
            if (i == 1) check("v0 decoded_cnt after drain", decoded_cnt, 32'd1);
        end
        @(posedge clk);
        #1;
        check("table drained", {31'b0, out_valid}, 32'd0);
        check("table decoded_cnt", decoded_cnt, 32'd16);
        check("table illegal_cnt", {16'b0, illegal_cnt}, 32'd6);

        // Backpressure: three words offered with out_ready low.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = W1;
        @(posedge clk);
        #1;
        check("bp c0 out_valid", {31'b0, out_valid}, 32'd1);
        check("bp c0 in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_inst = W2;
        @(posedge clk);
        #1;
        check("bp c1 in_ready", {31'b0, in_ready}, 32'd0);
        check("bp c1 rd", {27'b0, out_rd}, 32'd1);
        @(negedge clk);
        in_inst = W3;
        @(posedge clk);
        #1;
        check("bp c2 in_ready", {31'b0, in_ready}, 32'd0);
        check("bp c2 rd held", {27'b0, out_rd}, 32'd1);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp d0 out_valid", {31'b0, out_valid}, 32'd1);
        check("bp d0 rd", {27'b0, out_rd}, 32'd2);
        check("bp d0 in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp d1 out_valid", {31'b0, out_valid}, 32'd1);
        check("bp d1 rd", {27'b0, out_rd}, 32'd3);
        @(posedge clk);
        #1;
        check("bp done out_valid", {31'b0, out_valid}, 32'd0);
        check("bp decoded_cnt", decoded_cnt, 32'd19);

        // Flush with OR and SK both full and out_ready low.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = W1;
        @(posedge clk);
        @(negedge clk);
        in_inst = W2;
        @(posedge clk);
        #1;
        check("fl full in_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        flush   = 1'b1;
        in_inst = W3;
        @(posedge clk);
        #1;
        check("fl out_valid", {31'b0, out_valid}, 32'd0);
        check("fl in_ready", {31'b0, in_ready}, 32'd1);
        check("fl decoded_cnt", decoded_cnt, 32'd19);
        check("fl illegal_cnt", {16'b0, illegal_cnt}, 32'd6);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("fl stays empty", {31'b0, out_valid}, 32'd0);

        // Flush while accepting and draining: word dropped, handshake counted.
        @(negedge clk);
        in_valid = 1'b1;
        in_inst  = W1;
        @(posedge clk);
        @(negedge clk);
        flush     = 1'b1;
        out_ready = 1'b1;
        in_inst   = W2;
        @(posedge clk);
        #1;
        check("fl2 out_valid", {31'b0, out_valid}, 32'd0);
        check("fl2 decoded_cnt", decoded_cnt, 32'd20);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("fl2 word dropped", {31'b0, out_valid}, 32'd0);

        // Asynchronous reset mid-stream.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = W3;
        @(posedge clk);
        #1;
        check("mr pre out_valid", {31'b0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr out_valid", {31'b0, out_valid}, 32'd0);
        check("mr in_ready", {31'b0, in_ready}, 32'd1);
        check("mr out_rd", {27'b0, out_rd}, 32'd0);
        check("mr decoded_cnt", decoded_cnt, 32'd0);
        check("mr illegal_cnt", {16'b0, illegal_cnt}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mr after out_valid", {31'b0, out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
